uart_receiver: RTL

UART receive path, the counterpart of the existing transmit chain. It oversamples the serial `rx` line 16× using an internal baud tick generator. It deframes 8N1 characters, LSB first, and buffers each good byte in a first-word-fall-through FIFO. The block sits in the `clk100Mhz` domain and feeds received command bytes to downstream control logic, for example channel selection.

---
 rtl/uart_receiver_if.sv | 23 ++
 rtl/uart_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line, FIFO pop, FIFO head and status/error pulses.
interface uart_receiver_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            rd_uart;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rx_full;
  logic            frame_err;
  logic            overrun;
  logic            parity_err;

  modport master (
    output rx, rd_uart,
    input  r_data, rx_empty, rx_full, frame_err, overrun, parity_err
  );

  modport slave (
    input  rx, rd_uart,
    output r_data, rx_empty, rx_full, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver with FWFT FIFO; define UART_RX_PARITY_EN for one even-parity bit.
module uart_receiver #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned DVSR     = 326,
  parameter int unsigned DVSR_BIT = 9,
  parameter int unsigned FIFO_W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);
  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned Depth = 2 ** FIFO_W;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic rx_meta_q, rx_s_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic                tick;
  assign tick  = (cnt_q == DVSR_BIT'(DVSR - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  state_e          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            push;
  logic            full_q, full_d, empty_q, empty_d;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
  logic            parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: if (tick) begin
        if (s_q == 4'd7) begin
          // A start bit that is no longer low at mid-bit is a glitch.
          if (!rx_s_q) begin
            state_d = StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      StData: if (tick) begin
        if (s_q == 4'd15) begin
          b_d = {rx_s_q, b_q[DBIT-1:1]};
          s_d = '0;
          if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          s_d = s_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (tick) begin
        if (s_q == 4'd15) begin
          par_err_d = rx_s_q ^ (^b_q);
          s_d       = '0;
          state_d   = StStop;
        end else begin
          s_d = s_q + 4'd1;
        end
      end
`endif
      StStop: if (tick) begin
        if (s_q == 4'(SB_TICK - 1)) begin
          state_d = StIdle;
          // One error per frame: framing beats parity beats overrun.
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (full_q) begin
            overrun_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      state_q      <= StIdle;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  logic [DBIT-1:0]   mem_q [Depth];
  logic [FIFO_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_succ, rptr_succ;
  logic              rd_en;

  assign rd_en     = bus.rd_uart & ~empty_q;
  assign wptr_succ = wptr_q + 1'b1;
  assign rptr_succ = rptr_q + 1'b1;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({push, rd_en})
      2'b01: begin
        rptr_d  = rptr_succ;
        full_d  = 1'b0;
        empty_d = (rptr_succ == wptr_q);
      end
      2'b10: begin
        wptr_d  = wptr_succ;
        empty_d = 1'b0;
        full_d  = (wptr_succ == rptr_q);
      end
      2'b11: begin
        wptr_d = wptr_succ;
        rptr_d = rptr_succ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= b_q;
  end

  assign bus.r_data    = empty_q ? '0 : mem_q[rptr_q];
  assign bus.rx_empty  = empty_q;
  assign bus.rx_full   = full_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
